// File: rtl/clarvi_soc_led_pwm.sv
// clarvi_soc_led_pwm: Avalon-MM LED dimmer/blinker placed after the LED PIO.
// With enable clear the block is a registered pass-through of led_in.
module clarvi_soc_led_pwm #(
   parameter int NUM_LEDS      = 10,
   parameter int PWM_BITS      = 8,
   parameter int PRESCALE_BITS = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [1:0]          address,
   input  logic                chipselect,
   input  logic                write_n,
   input  logic [31:0]         writedata,
   output logic [31:0]         readdata,
   input  logic [NUM_LEDS-1:0] led_in,
   output logic [NUM_LEDS-1:0] led_out
);
   localparam logic [PWM_BITS-1:0] PWM_MAX  = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS-1:0] DUTY_RST = {1'b1, {(PWM_BITS-1){1'b0}}};

   logic                     enable_r;
   logic                     blink_en_r;
   logic [PWM_BITS-1:0]      duty_r;
   logic [PRESCALE_BITS-1:0] prescale_r;
   logic [PRESCALE_BITS-1:0] blink_r;
   logic [PRESCALE_BITS-1:0] pre_cnt_r;
   logic [PWM_BITS-1:0]      pwm_cnt_r;
   logic [PRESCALE_BITS-1:0] blink_cnt_r;
   logic                     phase_r;
   logic [NUM_LEDS-1:0]      led_out_r;

   logic                     wr_ctrl_s;
   logic                     wr_duty_s;
   logic                     wr_prescale_s;
   logic                     wr_blink_s;
   logic                     tick_s;
   logic                     frame_end_s;
   logic                     pwm_on_s;
   logic [NUM_LEDS-1:0]      led_next_s;
   logic                     unused_s;

   assign unused_s = ^writedata[31:PRESCALE_BITS];

   // Register write decode.
   always_comb begin
      wr_ctrl_s     = 1'b0;
      wr_duty_s     = 1'b0;
      wr_prescale_s = 1'b0;
      wr_blink_s    = 1'b0;
      if (chipselect && !write_n) begin
         case (address)
            2'd0:    wr_ctrl_s     = 1'b1;
            2'd1:    wr_duty_s     = 1'b1;
            2'd2:    wr_prescale_s = 1'b1;
            2'd3:    wr_blink_s    = 1'b1;
            default: wr_ctrl_s     = 1'b0;
         endcase
      end else begin
         wr_ctrl_s = 1'b0;
      end
   end

   // Configuration registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enable_r   <= 1'b0;
         blink_en_r <= 1'b0;
         duty_r     <= DUTY_RST;
         prescale_r <= '0;
         blink_r    <= '0;
      end else begin
         if (wr_ctrl_s) begin
            enable_r   <= writedata[0];
            blink_en_r <= writedata[1];
         end
         if (wr_duty_s)     duty_r     <= writedata[PWM_BITS-1:0];
         if (wr_prescale_s) prescale_r <= writedata[PRESCALE_BITS-1:0];
         if (wr_blink_s)    blink_r    <= writedata[PRESCALE_BITS-1:0];
      end
   end

   assign tick_s      = (pre_cnt_r == prescale_r);
   assign frame_end_s = tick_s && (pwm_cnt_r == PWM_MAX);

   // Prescaler, PWM and blink counters; holding them cleared while disabled
   // also gives the clean frame start on an enable 0->1 write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt_r   <= '0;
         pwm_cnt_r   <= '0;
         blink_cnt_r <= '0;
         phase_r     <= 1'b1;
      end else if (!enable_r) begin
         pre_cnt_r   <= '0;
         pwm_cnt_r   <= '0;
         blink_cnt_r <= '0;
         phase_r     <= 1'b1;
      end else begin
         pre_cnt_r <= (wr_prescale_s || tick_s) ? '0 : pre_cnt_r + PRESCALE_BITS'(1);
         if (tick_s) pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
         if (wr_blink_s) begin
            blink_cnt_r <= '0;
            phase_r     <= 1'b1;
         end else if (frame_end_s) begin
            if (blink_cnt_r == blink_r) begin
               blink_cnt_r <= '0;
               phase_r     <= ~phase_r;
            end else begin
               blink_cnt_r <= blink_cnt_r + PRESCALE_BITS'(1);
            end
         end
      end
   end

   // Full duty is forced on so the top count does not leave a one-tick gap.
   always_comb begin
      pwm_on_s = (duty_r == PWM_MAX) | (pwm_cnt_r < duty_r);
      if (enable_r) begin
         led_next_s = led_in & {NUM_LEDS{pwm_on_s & (~blink_en_r | phase_r)}};
      end else begin
         led_next_s = led_in;
      end
   end

   // LED output register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) led_out_r <= '0;
      else          led_out_r <= led_next_s;
   end

   assign led_out = led_out_r;

   // Combinational read-back, independent of chipselect.
   always_comb begin
      case (address)
         2'd0:    readdata = {30'd0, blink_en_r, enable_r};
         2'd1:    readdata = {{(32-PWM_BITS){1'b0}}, duty_r};
         2'd2:    readdata = {{(32-PRESCALE_BITS){1'b0}}, prescale_r};
         2'd3:    readdata = {{(32-PRESCALE_BITS){1'b0}}, blink_r};
         default: readdata = 32'd0;
      endcase
   end
endmodule

// File: tb/tb_clarvi_soc_led_pwm.sv
// Self-checking bench for clarvi_soc_led_pwm: random LED requests against a
// model built from tick and frame counts rather than the RTL counters.
module tb_clarvi_soc_led_pwm;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic [9:0]  led_in = 10'd0;
   logic [9:0]  led_out;

   int total = 0;
   int bad   = 0;

   // Reference model: configuration mirror plus counts of ticks since the
   // frame restart, cycles since the last tick, and frames since blink restart.
   bit   m_en, m_ben;
   int   m_duty, m_pre, m_blink;
   int   m_T, m_j, m_Fb;
   bit   rand_led = 1'b0;
   logic [9:0] led_fix = 10'd0;

   clarvi_soc_led_pwm dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .led_in(led_in), .led_out(led_out)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_en = 1'b0; m_ben = 1'b0; m_duty = 128; m_pre = 0; m_blink = 0;
      m_T = 0; m_j = 0; m_Fb = 0;
   endtask

   function automatic logic [9:0] exp_led(input logic [9:0] li);
      bit on;
      if (!m_en) return li;
      on = (m_duty == 255) || ((m_T % 256) < m_duty);
      if (m_ben && (((m_Fb / (m_blink + 1)) % 2) != 0)) on = 1'b0;
      return on ? li : 10'd0;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [1:0] a);
      case (a)
         2'd0:    return {30'd0, m_ben, m_en};
         2'd1:    return 32'(m_duty);
         2'd2:    return 32'(m_pre);
         default: return 32'(m_blink);
      endcase
   endfunction

   // One clock cycle with optional bus activity; checks led_out afterwards.
   task automatic cycle(input bit cs, input bit wn, input logic [1:0] a,
                        input logic [31:0] d, input string nm);
      logic [9:0] li;
      logic [9:0] exp_v;
      li = rand_led ? 10'($urandom) : led_fix;
      led_in = li; chipselect = cs; write_n = wn; address = a; writedata = d;
      exp_v = exp_led(li);
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
      total++;
      if (led_out !== exp_v) begin
         bad++;
         $display("FAIL %s: led_out=%h expected %h (ticks=%0d)", nm, led_out, exp_v, m_T);
      end
      if (m_en) begin
         if (m_j == m_pre) begin
            if ((m_T % 256) == 255) m_Fb++;
            m_T++;
            m_j = 0;
         end else begin
            m_j++;
         end
      end
      if (cs && !wn) begin
         case (a)
            2'd0: begin m_en = d[0]; m_ben = d[1]; end
            2'd1: m_duty = int'(d[7:0]);
            2'd2: begin m_pre = int'(d[15:0]); m_j = 0; end
            default: begin m_blink = int'(d[15:0]); m_Fb = 0; end
         endcase
      end
      if (!m_en) begin m_T = 0; m_j = 0; m_Fb = 0; end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      cycle(1'b1, 1'b0, a, d, "write_cycle");
   endtask

   task automatic idle(input int n, input string nm);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 2'd0, 32'd0, nm);
   endtask

   task automatic read_chk(input logic [1:0] a, input logic [31:0] e, input string nm);
      address = a; #1;
      total++;
      if (readdata !== e) begin
         bad++;
         $display("FAIL %s: readdata=%h expected %h", nm, readdata, e);
      end
   endtask

   task automatic configure(input int pre, input int duty, input int blink, input int ctrl);
      wr(2'd0, 32'd0);
      wr(2'd2, 32'(pre));
      wr(2'd1, 32'(duty));
      wr(2'd3, 32'(blink));
      wr(2'd0, 32'(ctrl));
   endtask

   task automatic test_reset();
      rand_led = 1'b0; led_fix = 10'h2A5; led_in = 10'h2A5;
      reset_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (led_out !== 10'h000) begin
         bad++; $display("FAIL reset_led: led_out=%h expected 000", led_out);
      end
      read_chk(2'd1, 32'h0000_0080, "reset_duty");
      read_chk(2'd0, 32'h0000_0000, "reset_ctrl");
      read_chk(2'd2, 32'h0000_0000, "reset_prescale");
      read_chk(2'd3, 32'h0000_0000, "reset_blink");
      @(negedge clk) reset_n = 1'b1;
      idle(4, "passthrough_after_reset");
   endtask

   task automatic test_pwm_duty();
      rand_led = 1'b1;
      configure(0, 64, 0, 1);
      idle(512, "duty64");
      wr(2'd1, 32'd0);
      idle(300, "duty0");
      wr(2'd1, 32'd255);
      idle(300, "duty255");
      configure($urandom_range(3, 0), $urandom_range(254, 1), 0, 1);
      idle(1024, "duty_random");
   endtask

   task automatic test_prescale();
      int cnt;
      rand_led = 1'b0; led_fix = 10'h3FF;
      configure(3, 1, 0, 1);
      cnt = 0;
      for (int i = 0; i < 1024; i++) begin
         cycle(1'b0, 1'b1, 2'd0, 32'd0, "prescale3");
         if (led_out != 10'd0) cnt++;
      end
      total++;
      if (cnt != 4) begin
         bad++; $display("FAIL prescale_on_count: on_cycles=%0d expected 4", cnt);
      end
      idle($urandom_range(300, 20), "prescale3_more");
      wr(2'd2, 32'd0);
      idle(600, "prescale_restart");
   endtask

   task automatic test_blink();
      rand_led = 1'b0; led_fix = 10'h001;
      configure(0, 255, 1, 3);
      idle(2048, "blink1");
      rand_led = 1'b1;
      configure(0, $urandom_range(255, 0), $urandom_range(2, 0), 3);
      idle(1500, "blink_random");
   endtask

   task automatic test_regs();
      logic [1:0] a;
      wr(2'd2, 32'hFFFF_FFFF);
      read_chk(2'd2, 32'h0000_FFFF, "prescale_mask");
      cycle(1'b0, 1'b0, 2'd1, 32'd5, "no_chipselect");
      read_chk(2'd1, exp_rd(2'd1), "duty_no_cs");
      cycle(1'b1, 1'b1, 2'd0, 32'd0, "no_write_n");
      read_chk(2'd0, exp_rd(2'd0), "ctrl_no_wr");
      for (int i = 0; i < 8; i++) begin
         a = 2'($urandom);
         wr(a, $urandom);
         read_chk(a, exp_rd(a), "random_rw");
      end
      idle(50, "after_random_rw");
   endtask

   task automatic test_reset_mid();
      rand_led = 1'b0; led_fix = 10'h001;
      configure(0, 255, 1, 3);
      idle(100, "blink_before_reset");
      reset_n = 1'b0;
      #1;
      total++;
      if (led_out !== 10'h000) begin
         bad++; $display("FAIL async_reset_led: led_out=%h expected 000", led_out);
      end
      model_reset();
      read_chk(2'd0, 32'h0000_0000, "mid_reset_ctrl");
      read_chk(2'd1, 32'h0000_0080, "mid_reset_duty");
      read_chk(2'd2, 32'h0000_0000, "mid_reset_prescale");
      read_chk(2'd3, 32'h0000_0000, "mid_reset_blink");
      led_fix = 10'h2A5; led_in = 10'h2A5;
      @(negedge clk) reset_n = 1'b1;
      idle(3, "passthrough_after_mid_reset");
   endtask

   initial begin
      test_reset();
      test_pwm_duty();
      test_prescale();
      test_blink();
      test_regs();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
